// File: rtl/encode_pkg.sv
// Shared RV32I encoding definitions: instruction format classes, base opcodes,
// and the opcode classifier used by both the encoder and the decoder.
package encode_pkg;

    // Instruction format class; ERROR marks an opcode with no RV32I format.
    typedef enum logic [2:0] {
        ERROR = 3'd0,
        R     = 3'd1,
        I     = 3'd2,
        S     = 3'd3,
        B     = 3'd4,
        U     = 3'd5,
        J     = 3'd6
    } inst_type_e;

    // RV32I base opcodes (instruction bits [6:0]).
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Buffered payload is {error flag, 32-bit instruction word}.
    localparam int PAYLOAD_W = 33;

    // Map an opcode onto its format class; unknown opcodes yield ERROR.
    function automatic inst_type_e classify_opcode(input logic [6:0] opcode);
        inst_type_e t;
        case (opcode)
            OPC_OP:     t = R;
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR,
            OPC_SYSTEM: t = I;
            OPC_STORE:  t = S;
            OPC_BRANCH: t = B;
            OPC_JAL:    t = J;
            OPC_LUI,
            OPC_AUIPC:  t = U;
            default:    t = ERROR;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/encode_skid.sv
// Two-entry skid buffer between the combinational encoder and the output port.
// Ready is derived only from stored occupancy, so downstream ready never
// reaches upstream ready combinationally.
module encode_skid
    import encode_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    output logic         push_ready_o,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [W-1:0] pop_data_o
);

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push;
    logic              pop;
    logic [1:0][W-1:0] entries;

    // Handshake qualification; clk_en low blocks both sides so state freezes.
    always_comb begin
        push = clk_en & push_valid_i & ~full_q;
        pop  = clk_en & ~empty_q & pop_ready_i;
    end

    // Port-facing flags; ready is also forced low while reset is held.
    assign push_ready_o = clk_en & ~rst & ~full_q;
    assign pop_valid_o  = clk_en & ~empty_q;
    assign pop_data_o   = entries[rd_ptr_q];

    // Next-state for pointers and occupancy; push+pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == 2'd2);
        empty_d = (count_d == 2'd0);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // One storage register per slot; cleared on reset so outputs read zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [W-1:0] entry_q;

        // Capture the pushed payload into the slot addressed by the write pointer.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_q <= '0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
                entry_q <= push_data_i;
            end
        end

        assign entries[gi] = entry_q;
    end

endmodule

// File: rtl/encode.sv
// RV32I instruction encoder: classifies the opcode, assembles the word from
// the field bundle, flags unencodable immediates, and buffers the result.
module encode
    import encode_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [4:0]           i_rd,
    input  logic [31:0]          i_imm,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_instruction,
    output logic                 o_error,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    inst_type_e             inst_type;
    logic [31:0]            word_asm;
    logic                   imm_ok;
    logic                   enc_error;
    logic                   fits_i;
    logic                   fits_b;
    logic                   fits_j;
    logic                   low_zero_u;
    logic [PAYLOAD_W-1:0]   payload;
    logic [PAYLOAD_W-1:0]   head_data;
    logic                   head_valid;
    logic                   pop_fire;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Immediate range checks: the bits above the encoded field must be a
    // pure sign extension, and branch/jump offsets must be halfword aligned.
    always_comb begin
        fits_i     = (&i_imm[31:11]) | ~(|i_imm[31:11]);
        fits_b     = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
        fits_j     = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];
        low_zero_u = ~(|i_imm[11:0]);
    end

    // Classify and assemble; an error bundle becomes an all-zero word.
    always_comb begin
        inst_type = classify_opcode(i_opcode);
        word_asm  = 32'h0000_0000;
        imm_ok    = 1'b1;
        case (inst_type)
            R: begin
                word_asm = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            I: begin
                word_asm = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                imm_ok   = fits_i;
            end
            S: begin
                word_asm = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                imm_ok   = fits_i;
            end
            B: begin
                word_asm = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:1], i_imm[11], i_opcode};
                imm_ok   = fits_b;
            end
            U: begin
                word_asm = {i_imm[31:12], i_rd, i_opcode};
                imm_ok   = low_zero_u;
            end
            J: begin
                word_asm = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                            i_rd, i_opcode};
                imm_ok   = fits_j;
            end
            default: begin
                imm_ok   = 1'b0;
            end
        endcase
        enc_error = ~imm_ok;
        payload   = {enc_error, (enc_error ? 32'h0000_0000 : word_asm)};
    end

    encode_skid #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .push_valid_i (i_valid),
        .push_data_i  (payload),
        .push_ready_o (o_ready),
        .pop_valid_o  (head_valid),
        .pop_ready_i  (i_ready),
        .pop_data_o   (head_data)
    );

    assign o_valid       = head_valid;
    assign o_instruction = head_data[31:0];
    assign o_error       = head_data[32];
    assign pop_fire      = head_valid & i_ready;
    assign o_err_count   = err_cnt_q;

    // Saturating count of error words actually handed downstream.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (pop_fire && head_data[32] && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_encode.sv
// Testbench for encode: directed steps followed by random traffic, checked
// against a queue-based reference built from RV32I format rules.
module tb_encode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [6:0]  i_opcode = '0;
    logic [2:0]  i_funct3 = '0;
    logic [6:0]  i_funct7 = '0;
    logic [4:0]  i_rs1 = '0;
    logic [4:0]  i_rs2 = '0;
    logic [4:0]  i_rd = '0;
    logic [31:0] i_imm = '0;

    logic        o_ready, o_valid, o_error;
    logic [31:0] o_instruction;
    logic [7:0]  o_err_count;
    logic        o2_ready, o2_valid, o2_error;
    logic [31:0] o2_instruction;
    logic [1:0]  o2_err_count;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [32:0] q[$];
    int cnt8 = 0;
    int cnt2 = 0;

    always #5 clk = ~clk;

    encode dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_imm(i_imm),
        .o_valid(o_valid), .i_ready(i_ready), .o_instruction(o_instruction),
        .o_error(o_error), .o_err_count(o_err_count)
    );

    encode #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .o_ready(o2_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_imm(i_imm),
        .o_valid(o2_valid), .i_ready(i_ready), .o_instruction(o2_instruction),
        .o_error(o2_error), .o_err_count(o2_err_count)
    );

    // Reference encoding from format rules, using numeric ranges for legality.
    function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [4:0] r1,
                                               input logic [4:0] r2, input logic [4:0] rd,
                                               input logic [31:0] imm);
        longint s;
        longint unsigned u, w, OP, F3, F7, R1, R2, RD;
        bit legal;
        s  = longint'($signed(imm));
        u  = 64'(imm);
        OP = 64'(op); F3 = 64'(f3); F7 = 64'(f7);
        R1 = 64'(r1); R2 = 64'(r2); RD = 64'(rd);
        w = 0;
        legal = 1'b1;
        case (op)
            7'b0110011: w = (F7 << 25) | (R2 << 20) | (R1 << 15) | (F3 << 12) | (RD << 7) | OP;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                legal = (s >= -2048) && (s <= 2047);
                w = ((u & 64'hfff) << 20) | (R1 << 15) | (F3 << 12) | (RD << 7) | OP;
            end
            7'b0100011: begin
                legal = (s >= -2048) && (s <= 2047);
                w = (((u >> 5) & 64'h7f) << 25) | (R2 << 20) | (R1 << 15) | (F3 << 12)
                  | ((u & 64'h1f) << 7) | OP;
            end
            7'b1100011: begin
                legal = (s >= -4096) && (s <= 4095) && ((u % 2) == 0);
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 64'h3f) << 25) | (R2 << 20)
                  | (R1 << 15) | (F3 << 12) | (((u >> 1) & 64'hf) << 8)
                  | (((u >> 11) & 1) << 7) | OP;
            end
            7'b1101111: begin
                legal = (s >= -1048576) && (s <= 1048575) && ((u % 2) == 0);
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 64'h3ff) << 21)
                  | (((u >> 11) & 1) << 20) | (((u >> 12) & 64'hff) << 12) | (RD << 7) | OP;
            end
            7'b0110111, 7'b0010111: begin
                legal = ((u % 4096) == 0);
                w = (u & 64'hffff_f000) | (RD << 7) | OP;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) return {1'b1, 32'h0000_0000};
        return {1'b0, w[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmp_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_bundle(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic [31:0] imm);
        i_opcode = op; i_funct3 = f3; i_funct7 = f7;
        i_rs1 = r1; i_rs2 = r2; i_rd = rd; i_imm = imm;
        i_valid = 1'b1;
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic tick(output bit pushed);
        bit exp_ready, exp_valid, do_pop;
        logic [32:0] head, captured;
        #1;
        exp_ready = clk_en && (q.size() < 2);
        exp_valid = clk_en && (q.size() > 0);
        chk("o_ready", 64'(o_ready), 64'(exp_ready));
        chk("o_valid", 64'(o_valid), 64'(exp_valid));
        if (exp_valid) begin
            head = q[0];
            chk("o_instruction", 64'(o_instruction), 64'(head[31:0]));
            chk("o_error", 64'(o_error), 64'(head[32]));
        end
        chk("err_count8", 64'(o_err_count), 64'(cnt8));
        chk("err_count2", 64'(o2_err_count), 64'(cnt2));
        pushed   = clk_en && i_valid && exp_ready;
        do_pop   = exp_valid && i_ready;
        captured = ref_encode(i_opcode, i_funct3, i_funct7, i_rs1, i_rs2, i_rd, i_imm);
        @(posedge clk);
        if (do_pop) begin
            head = q.pop_front();
            if (head[32]) begin
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3) cnt2++;
            end
            $display("txn pop word=%08h err=%0b", head[31:0], head[32]);
        end
        if (pushed) q.push_back(captured);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] w, input logic e);
        chk({tag, "_valid"}, 64'(o_valid), 64'(1));
        chk({tag, "_word"}, 64'(o_instruction), 64'(w));
        chk({tag, "_err"}, 64'(o_error), 64'(e));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'(0));
        chk({tag, "_ready"}, 64'(o_ready), 64'(0));
        chk({tag, "_word"}, 64'(o_instruction), 64'(0));
        chk({tag, "_err"}, 64'(o_error), 64'(0));
        chk({tag, "_cnt8"}, 64'(o_err_count), 64'(0));
        chk({tag, "_cnt2"}, 64'(o2_err_count), 64'(0));
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic apply_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state(tag);
        q.delete();
        cnt8 = 0;
        cnt2 = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit p;
        int idx;
        int guard;
        logic [6:0] ops [10];
        logic [31:0] imm;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

        // Power-on reset
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x2,5 appears one cycle after acceptance
        i_ready = 1'b1;
        set_bundle(7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd1, 32'd5);
        tick(p);
        i_valid = 1'b0;
        expect_out("addi", 32'h00510093, 1'b0);
        tick(p);

        // add then beq back-to-back
        set_bundle(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        tick(p);
        expect_out("add", 32'h002081B3, 1'b0);
        set_bundle(7'b1100011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        tick(p);
        i_valid = 1'b0;
        expect_out("beq", 32'h00208463, 1'b0);
        tick(p);

        // lui, jal, misaligned jal
        set_bundle(7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
        tick(p);
        expect_out("lui", 32'h123452B7, 1'b0);
        set_bundle(7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h800);
        tick(p);
        expect_out("jal", 32'h001000EF, 1'b0);
        set_bundle(7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h801);
        tick(p);
        i_valid = 1'b0;
        expect_out("jal_bad", 32'h0, 1'b1);
        tick(p);
        chk("jal_bad_cnt", 64'(o_err_count), 64'(1));

        // Backpressure: three bundles offered while downstream stalls
        i_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            set_bundle(7'b0010011, 3'(idx), 7'd0, 5'(idx), 5'd0, 5'(idx + 1), 32'(idx * 3));
            tick(p);
            if (p) idx++;
        end
        chk("bp_ready_low", 64'(o_ready), 64'(0));
        i_ready = 1'b1;
        guard = 0;
        while ((idx < 3 || q.size() > 0) && guard < 12) begin
            if (idx < 3) set_bundle(7'b0010011, 3'(idx), 7'd0, 5'(idx), 5'd0, 5'(idx + 1), 32'(idx * 3));
            else i_valid = 1'b0;
            tick(p);
            if (p) idx++;
            guard++;
        end
        i_valid = 1'b0;
        chk("bp_drain_in_time", 64'(guard < 12), 64'(1));

        // Saturation of the 2-bit counter
        apply_reset("rst_sat");
        for (int i = 0; i < 6; i++) begin
            if (i < 5) set_bundle(7'b0000000, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0);
            else i_valid = 1'b0;
            tick(p);
            if (i >= 1) chk("errsat2", 64'(o2_err_count), 64'((i > 3) ? 3 : i));
        end

        // Reset while the buffer is full
        i_ready = 1'b0;
        set_bundle(7'b0110011, 3'd1, 7'd32, 5'd4, 5'd5, 5'd6, 32'h0);
        tick(p);
        tick(p);
        chk("full_before_rst", 64'(o_ready), 64'(0));
        i_ready = 1'b1;
        apply_reset("rst_full");
        i_valid = 1'b0;
        tick(p);

        // clk_en low freezes everything
        i_ready = 1'b0;
        set_bundle(7'b0100011, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFF0);
        tick(p);
        clk_en = 1'b0;
        i_ready = 1'b1;
        set_bundle(7'b0010111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9, 32'hABCDE000);
        for (int i = 0; i < 3; i++) tick(p);
        clk_en = 1'b1;
        i_valid = 1'b0;
        tick(p);
        tick(p);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            clk_en  = ($urandom_range(0, 9) != 0);
            i_ready = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 8200)) - 32'd4100;
                1: imm = $urandom;
                2: imm = $urandom & 32'hFFFF_F000;
                default: imm = 32'($urandom_range(0, 8)) + (($urandom_range(0, 1) == 1) ? 32'h000F_FFFC : 32'hFFEF_FFFC);
            endcase
            set_bundle(($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)],
                       3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            i_valid = ($urandom_range(0, 9) < 6);
            tick(p);
        end
        i_valid = 1'b0;
        clk_en = 1'b1;
        i_ready = 1'b1;
        repeat (3) tick(p);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/encode.md
ENCODE -- requirements
Module: encode

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port clk_en, input, 1, global enable; state frozen when low.
REQ-005 SHALL have port i_valid, input, 1, upstream field bundle valid.
REQ-006 SHALL have port o_ready, output, 1, encoder can accept a bundle.
REQ-007 SHALL have ports i_opcode[6:0], i_funct3[2:0], i_funct7[6:0], i_rs1[4:0], i_rs2[4:0], i_rd[4:0], i_imm[31:0], inputs, the fields to encode.
REQ-008 SHALL have port o_valid, output, 1, encoded word available.
REQ-009 SHALL have port i_ready, input, 1, downstream accepts word.
REQ-010 SHALL have port o_instruction, output, 32, encoded RV32I word.
REQ-011 SHALL have port o_error, output, 1, qualifies o_instruction as an illegal or unencodable bundle.
REQ-012 SHALL have port o_err_count, output, ERR_CNT_W, saturating count of emitted error words.

Function
REQ-013 SHALL transfer input only when clk_en & i_valid & o_ready, and output only when clk_en & o_valid & i_ready.
REQ-014 SHALL classify i_opcode: 0110011=R; 0010011, 0000011, 1100111, 1110011=I; 0100011=S; 1100011=B; 1101111=J; 0110111, 0010111=U; others=ERROR.
REQ-015 SHALL assemble: R {funct7,rs2,rs1,funct3,rd,op}; I {imm[11:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-016 SHALL flag error when: type ERROR; I/S and imm[31:11] not all equal; B and (imm[31:12] not all equal or imm[0]=1); J and (imm[31:20] not all equal or imm[0]=1); U and imm[11:0]!=0.
REQ-017 SHALL, on error, emit o_instruction=32'h0000_0000 with o_error=1; the word still occupies a slot and follows the handshake.
REQ-018 SHALL ignore fields unused by the type (R ignores imm; I/S/B ignore funct7; U/J ignore funct3, funct7, rs1, rs2).
REQ-019 SHALL have latency of exactly one accepting cycle: a bundle accepted at edge N is presented with o_valid=1 after edge N when the buffer was empty.
REQ-020 SHALL buffer via a 2-entry skid buffer; o_ready=clk_en & (entries<2), registered from occupancy, no combinational path i_ready->o_ready.
REQ-021 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve order.
REQ-022 SHALL hold o_instruction/o_error stable while o_valid=1 and i_ready=0.
REQ-023 SHALL drive o_valid=0 and o_ready=0 while clk_en=0, with all registers held.
REQ-024 SHALL increment o_err_count when an error word is popped, saturating at all-ones.

Reset
REQ-025 SHALL, on rst asserted at any time including mid-transfer, immediately clear: buffer empty, o_valid=0, o_ready=0, o_instruction=0, o_error=0, o_err_count=0.
REQ-026 SHALL assert o_ready (given clk_en=1) in the first cycle after rst deasserts; buffered data lost by reset is not replayed.

Structure
REQ-027 SHALL place inst_type_e (ERROR,R,I,S,B,U,J; 3-bit) and the ten opcode constants in a shared package used by both this block and the decoder.
REQ-028 SHALL implement buffering in one sub-module encode_skid (2-entry, 33-bit payload = {error, word}); classification and assembly stay combinational in encode.

Verification
REQ-029 addi x1,x2,5 (op 0010011, f3 0, rs1 2, rd 1, imm 5) -> 0x00510093, o_error=0, one cycle later.
REQ-030 add x3,x1,x2 then beq x1,x2,+8 back-to-back, i_ready=1 -> 0x002081B3 then 0x00208463, consecutive cycles.
REQ-031 lui x5 imm 0x12345000 -> 0x123452B7; jal x1 imm 0x800 -> 0x001000EF; jal imm 0x801 -> 0x0, o_error=1, o_err_count=1.
REQ-032 i_ready=0 for 4 cycles with 3 bundles offered -> o_ready drops after 2 accepted, output held; release -> words in order, third accepted.
REQ-033 ERR_CNT_W=2, five opcode-0000000 bundles -> o_err_count 1,2,3,3,3.
REQ-034 rst pulsed while buffer holds 2 entries -> o_valid=0 and o_err_count=0 same cycle; clk_en=0 cycles -> no transfer, state held.
